pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen.sv | 147 ++++++++++++++
 tb/tb_pattern_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Test-pattern generator: colour bars, checkerboard, gradient and a bouncing box,
// producing one registered 12-bit RGB pixel per px_clk from the incoming raster coordinates.
module pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic        px_clk,
    input  logic        rst,
    input  logic [10:0] px_h,
    input  logic [10:0] px_v,
    input  logic [1:0]  mode,
    input  logic        pause,
    output logic [11:0] px_data,
    output logic        frame_tick
);

    localparam logic [10:0] H11    = 11'(H_ACTIVE);
    localparam logic [10:0] V11    = 11'(V_ACTIVE);
    localparam logic [10:0] BOX11  = 11'(BOX_SIZE);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_SIZE);

    typedef struct packed {
        logic [9:0] pos;
        logic       neg;
        logic       bounce;
    } axis_t;

    // One frame of motion on one axis; comparisons at 11 bits so pos+STEP cannot wrap.
    function automatic axis_t move_axis(input logic [9:0] pos, input logic neg,
                                        input logic [10:0] lim_max);
        axis_t r;
        r.pos    = pos;
        r.neg    = neg;
        r.bounce = 1'b0;
        if (!neg) begin
            if ({1'b0, pos} + STEP11 >= lim_max) begin
                r.pos    = 10'(lim_max);
                r.neg    = 1'b1;
                r.bounce = 1'b1;
            end else begin
                r.pos = 10'({1'b0, pos} + STEP11);
            end
        end else begin
            if ({1'b0, pos} <= STEP11) begin
                r.pos    = 10'd0;
                r.neg    = 1'b0;
                r.bounce = 1'b1;
            end else begin
                r.pos = 10'({1'b0, pos} - STEP11);
            end
        end
        return r;
    endfunction

    function automatic logic [11:0] bar_colour(input logic [10:0] h);
        logic [11:0] c;
        if      (h < 11'd80)  c = 12'hFFF;
        else if (h < 11'd160) c = 12'hFF0;
        else if (h < 11'd240) c = 12'h0FF;
        else if (h < 11'd320) c = 12'h0F0;
        else if (h < 11'd400) c = 12'hF0F;
        else if (h < 11'd480) c = 12'hF00;
        else if (h < 11'd560) c = 12'h00F;
        else                  c = 12'h000;
        return c;
    endfunction

    logic [1:0]  mode_q, mode_d;
    logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [11:0] box_col_q, box_col_d;
    logic [11:0] px_data_q, px_data_d;
    logic        frame_tick_q, frame_tick_d;

    logic        frame_start, active, in_box;
    logic [11:0] colour;
    axis_t       mv_x, mv_y;

    always_comb begin
        frame_start = (px_h == 11'd0) && (px_v == V11);
        active      = (px_h < H11) && (px_v < V11);
        in_box      = ({1'b0, box_x_q} <= px_h) && (px_h < {1'b0, box_x_q} + BOX11) &&
                      ({1'b0, box_y_q} <= px_v) && (px_v < {1'b0, box_y_q} + BOX11);
        mv_x        = move_axis(box_x_q, dir_x_q, X_MAX);
        mv_y        = move_axis(box_y_q, dir_y_q, Y_MAX);

        mode_d    = mode_q;
        box_x_d   = box_x_q;
        box_y_d   = box_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        box_col_d = box_col_q;
        if (frame_start) begin
            mode_d = mode;
            if (!pause) begin
                box_x_d = mv_x.pos;
                box_y_d = mv_y.pos;
                dir_x_d = mv_x.neg;
                dir_y_d = mv_y.neg;
                // F00 -> 0F0 -> 00F -> F00 is a 4-bit rotate right; a corner bounce rotates once.
                if (mv_x.bounce || mv_y.bounce) begin
                    box_col_d = {box_col_q[3:0], box_col_q[11:4]};
                end
            end
        end

        case (mode_q)
            2'd0:    colour = bar_colour(px_h);
            2'd1:    colour = (px_h[5] ^ px_v[5]) ? 12'hFFF : 12'h000;
            2'd2:    colour = {px_h[9:6], px_v[8:5], 4'h8};
            default: colour = in_box ? box_col_q : 12'h008;
        endcase

        px_data_d    = active ? colour : 12'h000;
        frame_tick_d = frame_start;
    end

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            mode_q       <= 2'd0;
            box_x_q      <= 10'd0;
            box_y_q      <= 10'd0;
            dir_x_q      <= 1'b0;
            dir_y_q      <= 1'b0;
            box_col_q    <= 12'hF00;
            px_data_q    <= 12'h000;
            frame_tick_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            box_x_q      <= box_x_d;
            box_y_q      <= box_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            box_col_q    <= box_col_d;
            px_data_q    <= px_data_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign px_data    = px_data_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: a reference model pushes the expected pixel/tick
// into a queue as each coordinate is driven; the entry is popped and compared one cycle later.
module tb_pattern_gen;

    localparam int H = 640;
    localparam int V = 480;
    localparam int B = 32;
    localparam int S = 2;

    logic        px_clk = 1'b0;
    logic        rst;
    logic [10:0] px_h, px_v;
    logic [1:0]  mode;
    logic        pause;
    logic [11:0] px_data;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;
    int fc = 0;

    int          bx, by;
    bit          xneg, yneg;
    logic [11:0] col;
    logic [1:0]  mode_m;

    logic [12:0] exp_q[$];

    always #5 px_clk = ~px_clk;

    pattern_gen dut (
        .px_clk    (px_clk),
        .rst       (rst),
        .px_h      (px_h),
        .px_v      (px_v),
        .mode      (mode),
        .pause     (pause),
        .px_data   (px_data),
        .frame_tick(frame_tick)
    );

    function automatic logic [11:0] model_pix(int h, int v);
        if (h >= H || v >= V) return 12'h000;
        case (mode_m)
            2'd0: begin
                case (h / 80)
                    0: return 12'hFFF;
                    1: return 12'hFF0;
                    2: return 12'h0FF;
                    3: return 12'h0F0;
                    4: return 12'hF0F;
                    5: return 12'hF00;
                    6: return 12'h00F;
                    default: return 12'h000;
                endcase
            end
            2'd1: return ((((h / 32) % 2) ^ ((v / 32) % 2)) != 0) ? 12'hFFF : 12'h000;
            2'd2: return {4'(h / 64), 4'(v / 32), 4'h8};
            default: return (h >= bx && h < bx + B && v >= by && v < by + B) ? col : 12'h008;
        endcase
    endfunction

    task automatic model_reset();
        bx = 0; by = 0; xneg = 0; yneg = 0; col = 12'hF00; mode_m = 2'd0;
    endtask

    task automatic model_frame(int m, bit p);
        bit bnc;
        mode_m = 2'(m);
        if (!p) begin
            bnc = 0;
            if (!xneg) begin
                if (bx + S >= H - B) begin bx = H - B; xneg = 1; bnc = 1; end
                else bx = bx + S;
            end else begin
                if (bx <= S) begin bx = 0; xneg = 0; bnc = 1; end
                else bx = bx - S;
            end
            if (!yneg) begin
                if (by + S >= V - B) begin by = V - B; yneg = 1; bnc = 1; end
                else by = by + S;
            end else begin
                if (by <= S) begin by = 0; yneg = 0; bnc = 1; end
                else by = by - S;
            end
            if (bnc) begin
                case (col)
                    12'hF00: col = 12'h0F0;
                    12'h0F0: col = 12'h00F;
                    default: col = 12'hF00;
                endcase
            end
        end
    endtask

    task automatic check(string tag, logic [11:0] got, logic [11:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // use_exp selects a hand-derived expected colour instead of the model's.
    task automatic drive(int h, int v, int m, bit p, string tag, bit use_exp, logic [11:0] exp_c);
        logic [11:0] e;
        logic [12:0] ent;
        bit          fs;
        px_h  = 11'(h);
        px_v  = 11'(v);
        mode  = 2'(m);
        pause = p;
        fs    = (h == 0 && v == V);
        e     = use_exp ? exp_c : model_pix(h, v);
        exp_q.push_back({fs, e});
        if (fs) model_frame(m, p);
        @(posedge px_clk);
        #1;
        ent = exp_q.pop_front();
        if (frame_tick === 1'b1) tick_seen++;
        check({tag, " px"}, px_data, ent[11:0]);
        check({tag, " tick"}, {11'b0, frame_tick}, {11'b0, ent[12]});
    endtask

    task automatic frame(int m, bit p);
        drive(0, V, m, p, "frame", 0, 12'h000);
        if (!p) fc++;
    endtask

    initial begin
        rst = 1'b1; px_h = 0; px_v = 0; mode = 0; pause = 0;
        model_reset();
        repeat (2) @(posedge px_clk);
        #1;
        check("reset px", px_data, 12'h000);
        check("reset tick", {11'b0, frame_tick}, 12'h000);
        rst = 1'b0;

        // Mode 0 straight out of reset
        drive(85, 10, 0, 0, "bar1", 1, 12'hFF0);
        drive(700, 10, 0, 0, "h_outside", 1, 12'h000);
        drive(0, 0, 0, 0, "bar0", 1, 12'hFFF);
        drive(320, 5, 0, 0, "bar4", 1, 12'hF0F);
        drive(639, 479, 0, 0, "bar7", 1, 12'h000);
        drive(100, 480, 0, 0, "v_outside", 1, 12'h000);
        drive(85, 10, 1, 0, "mode_not_latched", 1, 12'hFF0);

        // Checkerboard, then a mid-frame mode change that must not take effect
        frame(1, 0);
        drive(32, 0, 1, 0, "chk_32_0", 1, 12'hFFF);
        drive(32, 32, 1, 0, "chk_32_32", 1, 12'h000);
        drive(32, 0, 2, 0, "chk_hold_32_0", 1, 12'hFFF);
        drive(32, 32, 2, 0, "chk_hold_32_32", 1, 12'h000);
        frame(2, 0);
        drive(32, 0, 2, 0, "grad_32_0", 1, 12'h008);
        drive(100, 200, 2, 0, "grad_100_200", 1, 12'h168);

        // Three more frames in mode 3: five frame-starts since reset
        frame(3, 0);
        frame(3, 0);
        frame(3, 0);
        drive(10, 10, 3, 0, "box_10_10", 1, 12'hF00);
        drive(42, 10, 3, 0, "box_42_10", 1, 12'h008);
        drive(9, 10, 3, 0, "box_9_10", 1, 12'h008);
        drive(41, 41, 3, 0, "box_41_41", 1, 12'hF00);
        drive(10, 42, 3, 0, "box_10_42", 1, 12'h008);

        // Run to the right-edge bounce at frame 304 (y bounced earlier at frame 224)
        while (fc < 304) begin
            frame(3, 0);
            drive(bx, by, 3, 0, "run_probe", 0, 12'h000);
        end
        drive(608, 288, 3, 0, "xb_in", 1, 12'h00F);
        drive(607, 288, 3, 0, "xb_left", 1, 12'h008);
        drive(639, 319, 3, 0, "xb_corner", 1, 12'h00F);
        drive(608, 320, 3, 0, "xb_below", 1, 12'h008);
        frame(3, 0);
        drive(606, 286, 3, 0, "xb_next", 1, 12'h00F);
        drive(605, 286, 3, 0, "xb_next_left", 1, 12'h008);

        // Run to frame 4256, where x and y both hit a limit in the same frame
        while (fc < 4255) begin
            frame(3, 0);
            drive(bx, by, 3, 0, "run_probe2", 0, 12'h000);
        end
        drive(2, 446, 3, 0, "pre_corner", 1, 12'h0F0);
        frame(3, 0);
        drive(0, 448, 3, 0, "corner_in", 1, 12'h00F);
        drive(31, 479, 3, 0, "corner_far", 1, 12'h00F);
        drive(32, 448, 3, 0, "corner_right", 1, 12'h008);
        drive(0, 447, 3, 0, "corner_above", 1, 12'h008);

        // Pause: three frame-starts, position frozen, ticks still pulse, mode still latches
        tick_seen = 0;
        frame(3, 1);
        drive(0, 448, 3, 1, "pause1", 1, 12'h00F);
        frame(3, 1);
        drive(32, 448, 3, 1, "pause2", 1, 12'h008);
        frame(1, 1);
        drive(32, 0, 1, 1, "pause_mode", 1, 12'hFFF);
        checks++;
        assert (tick_seen === 3)
        else begin
            errors++;
            $error("FAIL pause_ticks: observed %0d expected %0d", tick_seen, 3);
        end
        frame(3, 1);
        drive(0, 448, 3, 1, "frozen_in", 1, 12'h00F);
        drive(32, 448, 3, 1, "frozen_right", 1, 12'h008);

        // Asynchronous reset in the middle of an active line
        drive(0, 448, 3, 0, "pre_rst", 1, 12'h00F);
        px_h = 11'd5; px_v = 11'd448; mode = 2'd3;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst px", px_data, 12'h000);
        check("async_rst tick", {11'b0, frame_tick}, 12'h000);
        @(posedge px_clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(85, 10, 3, 0, "post_rst_mode0", 1, 12'hFF0);
        frame(3, 1);
        drive(0, 0, 3, 1, "post_rst_box", 1, 12'hF00);
        drive(31, 31, 3, 1, "post_rst_box_far", 1, 12'hF00);
        drive(32, 0, 3, 1, "post_rst_box_right", 1, 12'h008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
